// File: rtl/ram_march_tester_if.sv
// rtl/ram_march_tester_if.sv - RAM port bundle between the march tester and a single-port RAM
interface ram_march_tester_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr_en;
    logic [DATA_W-1:0] ram_wr_data;
    logic [DATA_W-1:0] ram_rd_data;

    modport master (output ram_addr, ram_wr_en, ram_wr_data, input ram_rd_data);
    modport slave  (input ram_addr, ram_wr_en, ram_wr_data, output ram_rd_data);
endinterface

// File: rtl/ram_march_tester.sv
// rtl/ram_march_tester.sv - three-pass march BIST controller for a sync-write/async-read RAM
module ram_march_tester #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DATA_W-1:0]   seed,
    ram_march_tester_if.master  ram,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W+1:0]   err_count,
    output logic [ADDR_W-1:0]   fail_addr
);
    typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_VERIFY, ST_CHECK, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [ADDR_W+1:0]   err_q, err_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic                first_fail_q, first_fail_d;
    logic [DATA_W-1:0]   pat;
    logic                mismatch;
    logic                last;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        seed_d       = seed_q;
        err_d        = err_q;
        fail_addr_d  = fail_addr_q;
        first_fail_d = first_fail_q;
        pat          = cnt_q[DATA_W-1:0] ^ seed_q;
        last         = (cnt_q == {ADDR_W{1'b1}});
        mismatch     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_WRITE;
                    cnt_d        = '0;
                    seed_d       = seed;
                    err_d        = '0;
                    fail_addr_d  = '0;
                    first_fail_d = 1'b0;
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (last) state_d = ST_VERIFY;
            end
            ST_VERIFY: begin
                // Async read returns the pre-write value; the inverse lands at this edge.
                mismatch = (ram.ram_rd_data != pat);
                cnt_d    = cnt_q + ADDR_W'(1);
                if (last) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                mismatch = (ram.ram_rd_data != ~pat);
                cnt_d    = cnt_q + ADDR_W'(1);
                if (last) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (mismatch) begin
            if (err_q != {(ADDR_W+2){1'b1}}) err_d = err_q + (ADDR_W+2)'(1);
            if (!first_fail_q) begin
                fail_addr_d  = cnt_q;
                first_fail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            seed_q       <= '0;
            err_q        <= '0;
            fail_addr_q  <= '0;
            first_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seed_q       <= seed_d;
            err_q        <= err_d;
            fail_addr_q  <= fail_addr_d;
            first_fail_q <= first_fail_d;
        end
    end

    always_comb begin
        busy            = (state_q == ST_WRITE) || (state_q == ST_VERIFY) || (state_q == ST_CHECK);
        done            = (state_q == ST_DONE);
        pass            = done && (err_q == '0);
        ram.ram_addr    = busy ? cnt_q : '0;
        ram.ram_wr_en   = (state_q == ST_WRITE) || (state_q == ST_VERIFY);
        ram.ram_wr_data = (state_q == ST_WRITE)  ? pat :
                          (state_q == ST_VERIFY) ? ~pat : '0;
        err_count       = err_q;
        fail_addr       = fail_addr_q;
    end
endmodule

// File: tb/tb_ram_march_tester.sv
// tb/tb_ram_march_tester.sv - randomized self-checking bench for ram_march_tester with a faulty-RAM model
module tb_ram_march_tester;
    localparam int AW    = 5;
    localparam int DW    = 4;
    localparam int DEPTH = 32;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] seed  = '0;
    logic          busy, done, pass;
    logic [AW+1:0] err_count;
    logic [AW-1:0] fail_addr;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] s0  [DEPTH];
    logic [DW-1:0] s1  [DEPTH];

    int n_err    = 0;
    int n_checks = 0;

    ram_march_tester_if #(.ADDR_W(AW), .DATA_W(DW)) rif ();

    ram_march_tester #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .seed      (seed),
        .ram       (rif),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous write of the raw value, stuck-at faults applied on the async read.
    always @(posedge clk) if (rif.ram_wr_en) mem[rif.ram_addr] <= rif.ram_wr_data;
    assign rif.ram_rd_data = (mem[rif.ram_addr] & ~s0[rif.ram_addr]) | s1[rif.ram_addr];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int a, input logic [DW-1:0] s);
        return DW'(a) ^ s;
    endfunction

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            s0[a] = '0;
            s1[a] = '0;
        end
    endtask

    task automatic model(input logic [DW-1:0] s, output int e, output int fa);
        logic [DW-1:0] want, got;
        e  = 0;
        fa = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < DEPTH; a++) begin
                want = (ph == 0) ? pat(a, s) : ~pat(a, s);
                got  = (want & ~s0[a]) | s1[a];
                if (got != want) begin
                    if (e == 0) fa = a;
                    e++;
                end
            end
        end
        if (e > 127) e = 127;
    endtask

    task automatic run(input logic [DW-1:0] s, input bit pulse_busy, input string tag);
        int            e, fa, ph, a;
        logic [DW-1:0] p, wd;
        logic [127:0]  mexp, mgot;
        model(s, e, fa);
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
        seed  = DW'($urandom);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            ph = i / DEPTH;
            a  = i % DEPTH;
            p  = pat(a, s);
            wd = (ph == 0) ? p : ((ph == 1) ? ~p : '0);
            check($sformatf("%s.cyc%0d", tag, i),
                  {busy, done, rif.ram_wr_en, rif.ram_addr, rif.ram_wr_data},
                  {1'b1, 1'b0, (ph < 2), AW'(a), wd});
            start = pulse_busy && ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("%s.result", tag), {done, busy, pass, err_count, fail_addr},
              {1'b1, 1'b0, (e == 0), 7'(e), AW'(fa)});
        mexp = '0;
        mgot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            mexp[k*4 +: 4] = ~pat(k, s);
            mgot[k*4 +: 4] = mem[k];
        end
        check($sformatf("%s.mem", tag), mgot, mexp);
        @(negedge clk);
        check($sformatf("%s.hold", tag), {done, busy, rif.ram_wr_en}, 3'b100);
    endtask

    initial begin
        int q[$];
        int q0, q1;
        clear_faults();
        #1 reset = 1'b1;
        #2;
        check("reset", {busy, done, pass, rif.ram_wr_en, rif.ram_addr, rif.ram_wr_data, err_count, fail_addr}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run(4'h0, 1'b0, "seed0");
        run(4'hA, 1'b1, "seedA");
        check("seedA.mem0", {28'h0, mem[0]}, 32'h5);

        s0[5] = 4'b0100;
        run(4'h0, 1'b0, "sa0");
        check("sa0.spec", {pass, err_count, fail_addr}, {1'b0, 7'd1, 5'd5});

        clear_faults();
        s1[3]  = 4'b0001;
        s1[20] = 4'b0001;
        run(4'h0, 1'b1, "sa1");
        check("sa1.spec", {pass, err_count, fail_addr}, {1'b0, 7'd2, 5'd20});

        for (int r = 0; r < 4; r++) begin
            clear_faults();
            for (int k = 0; k < int'($urandom_range(0, 6)); k++) begin
                int fa_r;
                fa_r     = $urandom_range(0, DEPTH - 1);
                s0[fa_r] = DW'($urandom);
                s1[fa_r] = DW'($urandom) & ~s0[fa_r];
            end
            run(DW'($urandom), 1'b1, $sformatf("rand%0d", r));
        end

        clear_faults();
        s1[2] = 4'hF;
        @(negedge clk);
        start = 1'b1;
        seed  = 4'h3;
        @(negedge clk);
        start = 1'b0;
        repeat (42) @(negedge clk);
        check("mid.pre", {busy, rif.ram_wr_en, rif.ram_addr, err_count}, {1'b1, 1'b1, 5'd10, 7'd1});
        #2 reset = 1'b1;
        #1;
        check("mid.rst", {busy, done, rif.ram_wr_en, rif.ram_addr, err_count, fail_addr}, '0);
        @(negedge clk);
        reset = 1'b0;
        clear_faults();
        run(4'h5, 1'b0, "after_rst");
        check("after_rst.pass", {28'h0, 3'b0, pass}, 32'h1);

        @(negedge clk);
        start = 1'b1;
        seed  = 4'h0;
        for (int k = 1; k <= 250; k++) begin
            @(negedge clk);
            if (done) q.push_back(k - 1);
        end
        start = 1'b0;
        q0 = (q.size() > 0) ? q[0] : -1;
        q1 = (q.size() > 1) ? q[1] : -1;
        check("b2b.count", 128'(q.size()), 128'd2);
        check("b2b.first", 128'(q0), 128'd96);
        check("b2b.second", 128'(q1), 128'd193);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/ram_march_tester.md
Name: ram_march_tester

Overview:
- Built-in self-test controller that acts as the initiator for the team's 32x4 single-port RAM.
- The RAM has a synchronous write and an asynchronous read. This block drives the RAM's addr, wr_en and wr_data ports and samples its read_out.
- It runs a three-pass march (write pattern; read-verify and write the inverse; read-verify the inverse) and reports pass/fail, an error count and the first failing address.
- It sits beside the RAM at top level and is started from a switch or key.

Parameters:
- ADDR_W, 5, RAM address width; depth = 2**ADDR_W.
- DATA_W, 4, RAM data width; must be <= ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a test run; sampled only in IDLE or DONE.
- seed  input  DATA_W  pattern seed; latched when start is accepted.
- ram_addr  output  ADDR_W  address to the RAM.
- ram_wr_en  output  1  write enable to the RAM.
- ram_wr_data  output  DATA_W  write data to the RAM.
- ram_rd_data  input  DATA_W  RAM read_out; combinational from ram_addr.
- busy  output  1  high in WRITE, VERIFY and CHECK.
- done  output  1  high while in DONE.
- pass  output  1  valid when done=1; 1 iff err_count == 0.
- err_count  output  ADDR_W+2  number of mismatches, saturating at all-ones.
- fail_addr  output  ADDR_W  address of the first mismatch; 0 if none.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; address counter=0; seed register=0.
  - err_count=0, fail_addr=0, first-fail flag=0.
  - Outputs: busy=0, done=0, pass=0, ram_wr_en=0, ram_addr=0, ram_wr_data=0.
  - RAM contents are not touched.
- Pattern: P(a) = a[DATA_W-1:0] XOR seed_reg. The inverse pattern is ~P(a).
- States:
  - IDLE -> WRITE when start=1. On acceptance: latch seed, clear err_count, fail_addr and first-fail flag, set counter=0.
  - WRITE: ram_addr=cnt, ram_wr_en=1, ram_wr_data=P(cnt). Counter increments each cycle. On cnt = depth-1: counter wraps to 0 and state goes to VERIFY.
  - VERIFY: ram_addr=cnt, ram_wr_en=1, ram_wr_data=~P(cnt).
    - Compare ram_rd_data against P(cnt) in the same cycle; this is the pre-write value, valid because the RAM read is asynchronous and the write lands at the clock edge.
    - On mismatch, update the error registers at that edge.
    - At depth-1: counter wraps to 0 and state goes to CHECK.
  - CHECK: ram_addr=cnt, ram_wr_en=0, ram_wr_data=0. Compare ram_rd_data against ~P(cnt). At depth-1 go to DONE.
  - DONE: done=1, pass=(err_count==0). start=1 restarts exactly as from IDLE; otherwise stay in DONE.
- Outputs:
  - ram_addr, ram_wr_en and ram_wr_data are combinational decodes of the state and counter registers.
  - busy, done and pass are decoded from state.
- Error update on mismatch:
  - err_count increments, saturating at 2**(ADDR_W+2)-1.
  - If the first-fail flag is 0: fail_addr=cnt and the flag is set. Later mismatches do not change fail_addr.
- Latency: start accepted at edge N; done=1 after edge N+3*depth (96 cycles for the defaults).
- start while busy is ignored. start held high continuously gives back-to-back runs, with done high for exactly one cycle between runs.
- Reset mid-run: immediate return to IDLE with all outputs cleared; ram_wr_en drops asynchronously.

Test Plan:
- Fault-free RAM, seed=4'h0, start pulsed for 1 cycle:
  - busy for 96 cycles, then done=1, pass=1, err_count=0, fail_addr=0.
  - Memory after the run: mem[a] = ~(a[3:0]).
- Fault-free RAM, seed=4'hA:
  - During WRITE, wr_data sequence = A,B,8,9,...
  - Result pass=1; mem[0]=4'h5 after the run.
- Bench RAM model with bit 2 of address 5 stuck-at-0, seed=0:
  - VERIFY mismatch at address 5 (P=0101); CHECK matches (~P=1010).
  - Result err_count=1, fail_addr=5, pass=0.
- Stuck-at-1 on bit 0 of addresses 3 and 20, seed=0:
  - Mismatches: address 20 fails in VERIFY (P=0100); address 3 fails in CHECK (~P=1100).
  - Result err_count=2, fail_addr=20 (first in time), pass=0.
- Reset asserted between clock edges during VERIFY at cnt=10:
  - Immediately busy=0, ram_wr_en=0, err_count=0.
  - A subsequent start runs the full 96 cycles with pass=1.
- start held high for 250 cycles:
  - Two complete runs; done high for a single cycle at cycle 96 (and 193).
  - A pulse of start during busy has no effect on the cycle count.
